fnd_controller_gen: RTL and testbench

Parametrised N-digit multiplexed 7-segment (FND) display controller. It is the successor to the fixed 4-digit decimal controller and adds:
- configurable digit count and input width;
- a sequential binary-to-BCD converter (double-dabble, one bit per clock) with a load/busy handshake, replacing combinational divide/modulo;
- hex mode, leading-zero blanking, per-digit decimal points, per-digit blink and overflow indication.

It sits between datapath/UART logic and the board's common-anode display pins.

---
 rtl/fnd_controller_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_fnd_controller_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_controller_gen.sv
// N-digit multiplexed common-anode 7-segment controller with a one-bit-per-clock
// binary-to-BCD converter, hex mode, leading-zero blanking, decimal points and blink.
module fnd_controller_gen #(
    parameter int NUM_DIGITS = 4,
    parameter int IN_WIDTH   = 14,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int BLINK_DIV  = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   number,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] fndCom,
    output logic [7:0]            fndFont
);

    localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
    localparam int BCD_DIGITS = (IN_WIDTH * 302 + 1999) / 1000;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int MAX_AB     = (BCD_W > DISP_W) ? BCD_W : DISP_W;
    // Extra nibble guarantees a non-empty slice above the display digits.
    localparam int EXT_W      = ((MAX_AB > IN_WIDTH) ? MAX_AB : IN_WIDTH) + 4;
    localparam int CNT_W      = $clog2(IN_WIDTH + 1);
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int DIV_W      = $clog2(SCAN_DIV);
    localparam int BLK_W      = $clog2(BLINK_DIV + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   num_q, num_d;
    logic                  hex_q, hex_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic [EXT_W-1:0]      src_ext;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic                  phase_q, phase_d;
    logic                  tick;
    logic [NUM_DIGITS-1:0] com_q, com_d;
    logic [7:0]            font_q, font_d;
    logic [NUM_DIGITS:0]   hz;
    logic [3:0]            cur_nib;

    function automatic logic [7:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            4'hF: glyph = 8'h8E;
            default: glyph = 8'hFF;
        endcase
    endfunction

    // Converter FSM: capture, double-dabble shift, commit to display register.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        hex_d   = hex_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        src_ext = '0;
        bcd_adj = bcd_q;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end else begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4];
            end
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    num_d   = number;
                    hex_d   = hex_mode;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = hex_mode ? COMMIT : CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                bcd_d = (bcd_adj << 1) | BCD_W'(num_q[IN_WIDTH-1]);
                num_d = num_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
                    state_d = COMMIT;
                end else begin
                    state_d = CONV;
                end
            end
            COMMIT: begin
                src_ext = hex_q ? EXT_W'(num_q) : EXT_W'(bcd_q);
                disp_d  = src_ext[DISP_W-1:0];
                ovf_d   = |src_ext[EXT_W-1:DISP_W];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Scan divider, digit index and blink phase.
    always_comb begin
        tick    = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        idx_d   = idx_q;
        blk_d   = blk_q;
        phase_d = phase_q;
        if (tick) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
            if (blk_q == BLK_W'(BLINK_DIV - 1)) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + BLK_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Digit enable and segment pattern for the upcoming index, using next-state data
    // so a COMMIT coinciding with a tick shows new data at the new index at once.
    always_comb begin
        com_d = ~(NUM_DIGITS'(1) << idx_d);
        if (phase_d && blink_mask[idx_d]) begin
            com_d = '1;
        end else begin
            com_d = ~(NUM_DIGITS'(1) << idx_d);
        end
        hz[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hz[i] = hz[i+1] && (disp_d[4*i +: 4] == 4'd0);
        end
        cur_nib = disp_d[{idx_d, 2'b00} +: 4];
        if (ovf_d) begin
            font_d = 8'hBF;
        end else if (blank_lz && (idx_d != '0) && hz[idx_d]) begin
            font_d = 8'hFF;
        end else begin
            font_d = glyph(cur_nib);
        end
        if (dp_mask[idx_d]) begin
            font_d[7] = 1'b0;
        end else begin
            font_d[7] = font_d[7];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            hex_q   <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            com_q   <= ~NUM_DIGITS'(1);
            font_q  <= 8'hC0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            hex_q   <= hex_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            com_q   <= com_d;
            font_q  <= font_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign fndCom   = com_q;
    assign fndFont  = font_q;

endmodule

// File: tb/tb_fnd_controller_gen.sv
// Self-checking bench for fnd_controller_gen: directed scenarios plus randomized
// loads compared against an arithmetic model of digits, scan position and blink.
module tb_fnd_controller_gen;

    localparam int ND = 4;
    localparam int IW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] number = '0;
    logic          load = 1'b0;
    logic          hex_mode = 1'b0;
    logic          blank_lz = 1'b0;
    logic [ND-1:0] dp_mask = '0;
    logic [ND-1:0] blink_mask = '0;
    logic          busy;
    logic          overflow;
    logic [ND-1:0] fndCom;
    logic [7:0]    fndFont;

    int checks = 0;
    int failures = 0;
    int ref_val = 0;
    logic ref_hex = 1'b0;
    int n_edges = 0;
    int busy_hi = 0;
    int busy_rises = 0;
    logic busy_prev = 1'b0;

    localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    fnd_controller_gen #(
        .NUM_DIGITS(ND), .IN_WIDTH(IW), .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_DIV(2)
    ) dut (
        .clk(clk), .reset(reset), .number(number), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .blink_mask(blink_mask),
        .busy(busy), .overflow(overflow), .fndCom(fndCom), .fndFont(fndFont)
    );

    always #5 clk = ~clk;

    // Edges since reset release: scan position = (edges/10) mod 4, blink phase = (edges/20) mod 2.
    always @(posedge clk or posedge reset) begin
        if (reset) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    always @(negedge clk) begin
        if (busy) busy_hi++;
        if (busy && !busy_prev) busy_rises++;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_font(input int d);
        int base;
        int pw;
        int upper;
        logic [7:0] f;
        base = ref_hex ? 16 : 10;
        pw = 1;
        for (int j = 0; j < d; j++) pw = pw * base;
        upper = ref_val / pw;
        if (ref_val >= base * base * base * base) f = 8'hBF;
        else if (blank_lz && d > 0 && upper == 0) f = 8'hFF;
        else f = GLYPH[upper % base];
        if (dp_mask[d]) f[7] = 1'b0;
        return f;
    endfunction

    task automatic check_scan(input int cycles);
        int idx;
        int ph;
        logic [ND-1:0] ecom;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            idx = (n_edges / 10) % ND;
            ph = (n_edges / 20) % 2;
            ecom = ~(ND'(1) << idx);
            if (ph == 1 && blink_mask[idx]) ecom = '1;
            chk("fndCom", 32'(fndCom), 32'(ecom));
            chk("fndFont", 32'(fndFont), 32'(exp_font(idx)));
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic do_load(input int val, input logic hx, input int exp_busy);
        int cnt;
        @(posedge clk);
        #1;
        number = IW'(val);
        hex_mode = hx;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_len", 32'(cnt), 32'(exp_busy));
        ref_val = val;
        ref_hex = hx;
        chk("overflow", 32'(overflow), 32'((val >= (hx ? 65536 : 10000)) ? 1 : 0));
    endtask

    initial begin
        int a;
        int b;
        int k;
        int v;
        logic hx;

        repeat (2) @(negedge clk);
        chk("rst_com", 32'(fndCom), 32'(4'b1110));
        chk("rst_font", 32'(fndFont), 32'(8'hC0));
        reset = 1'b0;
        check_scan(25);

        // Reset in the middle of a conversion and mid-scan.
        @(posedge clk);
        #1;
        number = IW'(9999);
        hex_mode = 1'b0;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_com", 32'(fndCom), 32'(4'b1110));
        chk("arst_font", 32'(fndFont), 32'(8'hC0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_ovf", 32'(overflow), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        ref_val = 0;
        ref_hex = 1'b0;
        check_scan(45);

        // Decimal and hex loads, then overflow.
        do_load(1234, 1'b0, 15);
        check_scan(45);
        do_load(14'h3A5C, 1'b1, 1);
        check_scan(45);
        do_load(12345, 1'b0, 15);
        check_scan(45);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(42, 1'b0, 15);
        check_scan(45);
        @(posedge clk);
        #1;
        blank_lz = 1'b0;
        @(posedge clk);
        check_scan(45);
        @(posedge clk);
        #1;
        blank_lz = 1'b1;
        do_load(0, 1'b0, 15);
        check_scan(45);

        // Loads while busy are ignored; a load when busy falls is accepted.
        a = 777;
        b = 3210;
        busy_hi = 0;
        busy_rises = 0;
        @(posedge clk);
        #1;
        number = IW'(a);
        hex_mode = 1'b0;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 3 || c == 8) begin
                number = IW'(c == 3 ? 5555 : 6666);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("falls_to", 32'(busy), 32'(0));
        number = IW'(b);
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        wait_idle();
        chk("busy_pulses", 32'(busy_rises), 32'(2));
        chk("busy_cycles", 32'(busy_hi), 32'(30));
        ref_val = b;
        ref_hex = 1'b0;
        blank_lz = 1'b0;
        @(posedge clk);
        check_scan(45);

        // Decimal point and blink.
        @(posedge clk);
        #1;
        dp_mask = 4'b0100;
        blink_mask = 4'b0001;
        @(posedge clk);
        check_scan(100);

        // Randomized loads and live controls.
        for (int r = 0; r < 20; r++) begin
            v = int'($urandom_range(0, 16383));
            hx = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            blank_lz = 1'($urandom_range(0, 1));
            dp_mask = 4'($urandom_range(0, 15));
            blink_mask = 4'($urandom_range(0, 15));
            do_load(v, hx, hx ? 1 : 15);
            check_scan(45);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
